// File: rtl/si_alien_pkg.sv
// Shared types and constants for the alien-field controller.
package si_alien_pkg;

    localparam int unsigned ROW_W    = 8;
    localparam int unsigned NUM_ROWS = 7;
    localparam int unsigned SCORE_W  = 5;
    // Wide enough for the current score plus every alien hit in one cycle (31 + 56).
    localparam int unsigned SUM_W    = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } state_t;

    // Number of set bits in one matrix row.
    function automatic logic [3:0] popcount8(input logic [ROW_W-1:0] row);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < int'(ROW_W); i++) begin
            n = n + 4'(row[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/si_tick_counter.sv
// Formation-move prescaler: one-cycle tick every TICKS enabled clocks.
module si_tick_counter #(
    parameter int unsigned TICKS = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned     CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap   = (r_cnt == LAST);
    assign o_tick_c = i_en & w_wrap & ~i_clr;

    // Count while enabled, wrap at TICKS-1, hold otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/si_alien_field.sv
// Alien formation storage, bullet hit detection, march and game FSM.
// Optional horizontal march: define SI_ALIEN_FIELD_MARCH_EN.
module si_alien_field
    import si_alien_pkg::*;
#(
    parameter int unsigned      DESCENT_TICKS = 50_000_000,
    parameter logic [ROW_W-1:0] INIT_ROW7     = 8'h7E,
    parameter logic [ROW_W-1:0] INIT_ROW6     = 8'h3C
) (
    input  logic               SI_ALIEN_FIELD_CLOCK_50,
    input  logic               SI_ALIEN_FIELD_RESET_InHigh,
    input  logic               SI_ALIEN_FIELD_START_InLow,
    input  logic [ROW_W-1:0]   SI_ALIEN_FIELD_BULLET_FILA1,
    input  logic [ROW_W-1:0]   SI_ALIEN_FIELD_BULLET_FILA2,
    input  logic [ROW_W-1:0]   SI_ALIEN_FIELD_BULLET_FILA3,
    input  logic [ROW_W-1:0]   SI_ALIEN_FIELD_BULLET_FILA4,
    input  logic [ROW_W-1:0]   SI_ALIEN_FIELD_BULLET_FILA5,
    input  logic [ROW_W-1:0]   SI_ALIEN_FIELD_BULLET_FILA6,
    input  logic [ROW_W-1:0]   SI_ALIEN_FIELD_BULLET_FILA7,
    output logic [ROW_W-1:0]   SI_ALIEN_FIELD_FILA1,
    output logic [ROW_W-1:0]   SI_ALIEN_FIELD_FILA2,
    output logic [ROW_W-1:0]   SI_ALIEN_FIELD_FILA3,
    output logic [ROW_W-1:0]   SI_ALIEN_FIELD_FILA4,
    output logic [ROW_W-1:0]   SI_ALIEN_FIELD_FILA5,
    output logic [ROW_W-1:0]   SI_ALIEN_FIELD_FILA6,
    output logic [ROW_W-1:0]   SI_ALIEN_FIELD_FILA7,
    output logic               SI_ALIEN_FIELD_STATE_BULLET_OutLow,
    output logic [SCORE_W-1:0] SI_ALIEN_FIELD_SCORE,
    output logic               SI_ALIEN_FIELD_WIN,
    output logic               SI_ALIEN_FIELD_LOSE
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'((1 << SCORE_W) - 1);

    // Index 0 is row 1, index NUM_ROWS-1 is row 7.
    typedef logic [NUM_ROWS-1:0][ROW_W-1:0] rows_t;

    state_t             r_state;
    state_t             w_state_nxt;
    rows_t              r_rows;
    rows_t              w_rows_nxt;
    rows_t              w_rows_clr;
    rows_t              w_bullet;
    rows_t              w_hit;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nxt;
    logic               r_bullet_n;
    logic               w_bullet_n_nxt;
    logic               r_win;
    logic               r_lose;
    logic [SUM_W-1:0]   w_hit_cnt;
    logic [SUM_W-1:0]   w_score_sum;
    logic               w_hit_any;
    logic               w_bus_empty;
    logic               w_tick;
    logic               w_cnt_en;
    logic               w_cnt_clr;
`ifdef SI_ALIEN_FIELD_MARCH_EN
    logic               r_dir;      // 0 = moving right (toward bit 0), 1 = left
    logic               w_dir_nxt;
    logic               w_col0;
    logic               w_col7;
`endif

    assign w_bullet = {SI_ALIEN_FIELD_BULLET_FILA7, SI_ALIEN_FIELD_BULLET_FILA6,
                       SI_ALIEN_FIELD_BULLET_FILA5, SI_ALIEN_FIELD_BULLET_FILA4,
                       SI_ALIEN_FIELD_BULLET_FILA3, SI_ALIEN_FIELD_BULLET_FILA2,
                       SI_ALIEN_FIELD_BULLET_FILA1};
    assign w_hit       = w_bullet & r_rows;
    assign w_hit_any   = |w_hit;
    assign w_bus_empty = ~|w_bullet;

    // Prescaler runs only in PLAY and restarts on every game load.
    assign w_cnt_en  = (r_state == ST_PLAY);
    assign w_cnt_clr = (r_state == ST_LOAD);

    si_tick_counter #(
        .TICKS (DESCENT_TICKS)
    ) u_tick (
        .i_clk    (SI_ALIEN_FIELD_CLOCK_50),
        .i_rst    (SI_ALIEN_FIELD_RESET_InHigh),
        .i_en     (w_cnt_en),
        .i_clr    (w_cnt_clr),
        .o_tick_c (w_tick)
    );

    // Total aliens struck this cycle and the saturating score candidate.
    always_comb begin
        w_hit_cnt = '0;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            w_hit_cnt = w_hit_cnt + SUM_W'(popcount8(w_hit[r]));
        end
        w_score_sum = SUM_W'(r_score) + w_hit_cnt;
    end

`ifdef SI_ALIEN_FIELD_MARCH_EN
    // Edge columns occupied after the hit clear decide march versus descend.
    always_comb begin
        w_col0 = 1'b0;
        w_col7 = 1'b0;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            w_col0 = w_col0 | w_rows_clr[r][0];
            w_col7 = w_col7 | w_rows_clr[r][ROW_W-1];
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge SI_ALIEN_FIELD_CLOCK_50 or posedge SI_ALIEN_FIELD_RESET_InHigh) begin
        if (SI_ALIEN_FIELD_RESET_InHigh) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next formation, score and bullet handshake.
    always_comb begin
        w_state_nxt    = r_state;
        w_rows_clr     = r_rows;
        w_rows_nxt     = r_rows;
        w_score_nxt    = r_score;
        w_bullet_n_nxt = r_bullet_n;
`ifdef SI_ALIEN_FIELD_MARCH_EN
        w_dir_nxt      = r_dir;
`endif

        // Consumed bullet is released once the shooter's bus is empty.
        if (!r_bullet_n && w_bus_empty) begin
            w_bullet_n_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (!SI_ALIEN_FIELD_START_InLow) begin
                    w_state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                w_rows_nxt             = '0;
                w_rows_nxt[NUM_ROWS-1] = INIT_ROW7;
                w_rows_nxt[NUM_ROWS-2] = INIT_ROW6;
                w_score_nxt            = '0;
                w_bullet_n_nxt         = 1'b1;
`ifdef SI_ALIEN_FIELD_MARCH_EN
                w_dir_nxt              = 1'b0;
`endif
                w_state_nxt            = ST_PLAY;
            end

            ST_PLAY: begin
                // Hits only count while the previous bullet is released.
                if (r_bullet_n && w_hit_any) begin
                    w_rows_clr     = r_rows & ~w_hit;
                    w_bullet_n_nxt = 1'b0;
                    if (w_score_sum > SUM_W'(SCORE_MAX)) begin
                        w_score_nxt = SCORE_MAX;
                    end else begin
                        w_score_nxt = w_score_sum[SCORE_W-1:0];
                    end
                end
                w_rows_nxt = w_rows_clr;

                // Move is applied to the already-cleared formation.
                if (w_tick) begin
`ifdef SI_ALIEN_FIELD_MARCH_EN
                    if ((!r_dir && w_col0) || (r_dir && w_col7)) begin
                        w_rows_nxt = {{ROW_W{1'b0}}, w_rows_clr[NUM_ROWS-1:1]};
                        w_dir_nxt  = ~r_dir;
                    end else begin
                        for (int r = 0; r < int'(NUM_ROWS); r++) begin
                            w_rows_nxt[r] = r_dir ? (w_rows_clr[r] << 1) : (w_rows_clr[r] >> 1);
                        end
                    end
`else
                    w_rows_nxt = {{ROW_W{1'b0}}, w_rows_clr[NUM_ROWS-1:1]};
`endif
                end

                // Terminal check on the formation committed by the previous update.
                if (r_rows == '0) begin
                    w_state_nxt = ST_WIN;
                end else if (r_rows[0] != '0) begin
                    w_state_nxt = ST_LOSE;
                end
            end

            ST_WIN, ST_LOSE: begin
                if (!SI_ALIEN_FIELD_START_InLow) begin
                    w_state_nxt = ST_LOAD;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered formation, score, handshake and result flags.
    always_ff @(posedge SI_ALIEN_FIELD_CLOCK_50 or posedge SI_ALIEN_FIELD_RESET_InHigh) begin
        if (SI_ALIEN_FIELD_RESET_InHigh) begin
            r_rows     <= '0;
            r_score    <= '0;
            r_bullet_n <= 1'b1;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
`ifdef SI_ALIEN_FIELD_MARCH_EN
            r_dir      <= 1'b0;
`endif
        end else begin
            r_rows     <= w_rows_nxt;
            r_score    <= w_score_nxt;
            r_bullet_n <= w_bullet_n_nxt;
            r_win      <= (w_state_nxt == ST_WIN);
            r_lose     <= (w_state_nxt == ST_LOSE);
`ifdef SI_ALIEN_FIELD_MARCH_EN
            r_dir      <= w_dir_nxt;
`endif
        end
    end

    assign SI_ALIEN_FIELD_FILA1               = r_rows[0];
    assign SI_ALIEN_FIELD_FILA2               = r_rows[1];
    assign SI_ALIEN_FIELD_FILA3               = r_rows[2];
    assign SI_ALIEN_FIELD_FILA4               = r_rows[3];
    assign SI_ALIEN_FIELD_FILA5               = r_rows[4];
    assign SI_ALIEN_FIELD_FILA6               = r_rows[5];
    assign SI_ALIEN_FIELD_FILA7               = r_rows[6];
    assign SI_ALIEN_FIELD_STATE_BULLET_OutLow = r_bullet_n;
    assign SI_ALIEN_FIELD_SCORE               = r_score;
    assign SI_ALIEN_FIELD_WIN                 = r_win;
    assign SI_ALIEN_FIELD_LOSE                = r_lose;

endmodule
